tia_hsync_sequencer: RTL and testbench

TIA_HSYNC_SEQUENCER -- requirements
Module: tia_hsync_sequencer

---
 rtl/tia_hsync_sequencer.sv | 152 +++++++++++++++
 tb/tb_tia_hsync_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tia_hsync_sequencer.sv
// tia_hsync_sequencer
//   Horizontal timing sequencer. A 2-bit phase counter divides the colour
//   clock by four; every time it wraps, the 57-slot horizontal counter
//   advances. Slot decodes mark the hblank/hsync/colour-burst events of a
//   228-clock scan line. RSYNC restarts the line. HMOVE strobes are held
//   until the next phase-1 horizontal clock.
//
// Ports
//   clk       : colour clock, the only clock, rising-edge active
//   reset_bar : asynchronous active-low reset
//   rsync     : one-clk strobe, restart the line at slot 0
//   hmove     : one-clk strobe, request an hmove_q pulse
//   hphi1     : phase-1 horizontal clock, high for phase 0 of each slot
//   hphi2     : phase-2 horizontal clock, high for phase 2 of each slot
//   shb       : slot 0 decode (set hblank)
//   shs       : SHS_CNT decode (set hsync)
//   rhs       : RHS_CNT decode (reset hsync)
//   rcb       : RCB_CNT decode (reset colour burst)
//   rhb       : RHB_CNT decode (reset hblank)
//   lrhb      : LRHB_CNT decode (late reset hblank)
//   cnt       : CNT_CNT decode (line centre)
//   rsynd     : high for the whole first slot after an rsync
//   hmove_q   : hmove request re-timed onto hphi1
//   hcount    : current slot number, 0..HSC_LAST

module tia_hsync_sequencer #(
  parameter int HSC_LAST = 56,
  parameter int SHS_CNT  = 4,
  parameter int RHS_CNT  = 8,
  parameter int RCB_CNT  = 12,
  parameter int RHB_CNT  = 16,
  parameter int LRHB_CNT = 18,
  parameter int CNT_CNT  = 36
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       rsync,
  input  logic       hmove,
  output logic       hphi1,
  output logic       hphi2,
  output logic       shb,
  output logic       shs,
  output logic       rhs,
  output logic       rcb,
  output logic       rhb,
  output logic       lrhb,
  output logic       cnt,
  output logic       rsynd,
  output logic       hmove_q,
  output logic [5:0] hcount
);

  // Every decode slot must be a real slot and no two decodes may share one.
  function automatic bit cfg_ok();
    int  slots [6];
    bit  ok;
    slots[0] = SHS_CNT;
    slots[1] = RHS_CNT;
    slots[2] = RCB_CNT;
    slots[3] = RHB_CNT;
    slots[4] = LRHB_CNT;
    slots[5] = CNT_CNT;
    ok = (HSC_LAST >= 1) && (HSC_LAST <= 63);
    for (int i = 0; i < 6; i++) begin
      if ((slots[i] < 0) || (slots[i] > HSC_LAST)) ok = 1'b0;
      for (int j = i + 1; j < 6; j++) begin
        if (slots[i] == slots[j]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  if (!cfg_ok()) begin : g_cfg_error
    $error("tia_hsync_sequencer: decode slot out of range 0..HSC_LAST or duplicated");
  end

  localparam logic [5:0] LAST_SLOT = 6'(HSC_LAST);
  localparam logic [5:0] SHS_SLOT  = 6'(SHS_CNT);
  localparam logic [5:0] RHS_SLOT  = 6'(RHS_CNT);
  localparam logic [5:0] RCB_SLOT  = 6'(RCB_CNT);
  localparam logic [5:0] RHB_SLOT  = 6'(RHB_CNT);
  localparam logic [5:0] LRHB_SLOT = 6'(LRHB_CNT);
  localparam logic [5:0] CNT_SLOT  = 6'(CNT_CNT);

  logic [1:0] phase;
  logic [1:0] phase_nxt;
  logic [5:0] hcount_nxt;
  logic       slot_end;
  logic       hmove_pend;
  logic       hmove_fire;

  // Next-state values. All registered outputs are decoded from these so
  // that they line up with the phase/hcount registers on the same edge.
  // rsync overrides the normal count and restarts slot 0 immediately, so a
  // partly elapsed slot is simply abandoned. An hmove arriving in the clk
  // that lands on phase 0 fires straight away instead of waiting a slot.
  always_comb begin
    slot_end   = (phase == 2'd3);
    phase_nxt  = rsync ? 2'd0 : phase + 2'd1;
    hcount_nxt = hcount;
    if (rsync) begin
      hcount_nxt = '0;
    end else if (slot_end) begin
      hcount_nxt = (hcount == LAST_SLOT) ? 6'd0 : hcount + 6'd1;
    end
    hmove_fire = (phase_nxt == 2'd0) && (hmove_pend || hmove);
  end

  // Counter and output registers. Reset leaves the sequencer sitting at
  // phase 0 of slot 0, so hphi1 and shb are high while reset is held.
  // rsynd is set by rsync and cleared at the natural end of the slot, which
  // stretches it across repeated rsyncs. An hmove seen in the clk that
  // issues hmove_q re-arms the pending flag for the next slot.
  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      phase      <= 2'd0;
      hcount     <= 6'd0;
      hphi1      <= 1'b1;
      hphi2      <= 1'b0;
      shb        <= 1'b1;
      shs        <= 1'b0;
      rhs        <= 1'b0;
      rcb        <= 1'b0;
      rhb        <= 1'b0;
      lrhb       <= 1'b0;
      cnt        <= 1'b0;
      rsynd      <= 1'b0;
      hmove_q    <= 1'b0;
      hmove_pend <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      hcount  <= hcount_nxt;
      hphi1   <= (phase_nxt == 2'd0);
      hphi2   <= (phase_nxt == 2'd2);
      shb     <= (hcount_nxt == 6'd0);
      shs     <= (hcount_nxt == SHS_SLOT);
      rhs     <= (hcount_nxt == RHS_SLOT);
      rcb     <= (hcount_nxt == RCB_SLOT);
      rhb     <= (hcount_nxt == RHB_SLOT);
      lrhb    <= (hcount_nxt == LRHB_SLOT);
      cnt     <= (hcount_nxt == CNT_SLOT);
      if (rsync) begin
        rsynd <= 1'b1;
      end else if (slot_end) begin
        rsynd <= 1'b0;
      end
      hmove_q    <= hmove_fire;
      hmove_pend <= hmove_fire ? 1'b0 : (hmove_pend || hmove);
    end
  end

endmodule

// File: tb/tb_tia_hsync_sequencer.sv
// tb_tia_hsync_sequencer
//   Self-checking bench for tia_hsync_sequencer. A directed table covers the
//   first slots after reset; a line-position model then feeds a scoreboard
//   queue for free-running, rsync, hmove and reset scenarios.

module tb_tia_hsync_sequencer;

  logic       clk = 1'b0;
  logic       reset_bar;
  logic       rsync;
  logic       hmove;
  logic       hphi1, hphi2, shb, shs, rhs, rcb, rhb, lrhb, cnt, rsynd, hmove_q;
  logic [5:0] hcount;

  tia_hsync_sequencer dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .rsync     (rsync),
    .hmove     (hmove),
    .hphi1     (hphi1),
    .hphi2     (hphi2),
    .shb       (shb),
    .shs       (shs),
    .rhs       (rhs),
    .rcb       (rcb),
    .rhb       (rhb),
    .lrhb      (lrhb),
    .cnt       (cnt),
    .rsynd     (rsynd),
    .hmove_q   (hmove_q),
    .hcount    (hcount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] hcount;
    logic       hphi1;
    logic       hphi2;
    logic       shb;
    logic       shs;
    logic       rhs;
    logic       rcb;
    logic       rhb;
    logic       lrhb;
    logic       cnt;
    logic       rsynd;
    logic       hmove_q;
  } outs_t;

  typedef struct {
    logic  rsync;
    logic  hmove;
    outs_t exp;
  } vec_t;

  outs_t exp_q  [$];
  string name_q [$];
  vec_t  vecs   [16];
  int    checks = 0;
  int    passes = 0;

  // Line-position model: m_t is the clock index within the 228-clk line.
  int m_t;
  bit m_rsynd, m_pend, m_hmq;

  // Tracking for the hmove scenarios.
  int trk_step, trk_n, trk_first, trk_second, trk_bad;

  function automatic outs_t mk(logic [5:0] hc, logic p1, logic p2, logic sb,
                               logic rd, logic hq);
    outs_t o;
    o = '0;
    o.hcount  = hc;
    o.hphi1   = p1;
    o.hphi2   = p2;
    o.shb     = sb;
    o.rsynd   = rd;
    o.hmove_q = hq;
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o = {hcount, hphi1, hphi2, shb, shs, rhs, rcb, rhb, lrhb, cnt, rsynd, hmove_q};
    return o;
  endfunction

  function automatic outs_t model_outs();
    outs_t o;
    int hc, ph;
    hc = m_t / 4;
    ph = m_t % 4;
    o = '0;
    o.hcount  = 6'(hc);
    o.hphi1   = (ph == 0);
    o.hphi2   = (ph == 2);
    o.shb     = (hc == 0);
    o.shs     = (hc == 4);
    o.rhs     = (hc == 8);
    o.rcb     = (hc == 12);
    o.rhb     = (hc == 16);
    o.lrhb    = (hc == 18);
    o.cnt     = (hc == 36);
    o.rsynd   = m_rsynd;
    o.hmove_q = m_hmq;
    return o;
  endfunction

  task automatic modelReset();
    m_t = 0; m_rsynd = 1'b0; m_pend = 1'b0; m_hmq = 1'b0;
  endtask

  task automatic modelStep(input logic rs, input logic hm);
    int old_ph;
    old_ph = m_t % 4;
    if (rs) m_t = 0;
    else    m_t = (m_t + 1) % 228;
    if (rs)               m_rsynd = 1'b1;
    else if (old_ph == 3) m_rsynd = 1'b0;
    m_hmq  = ((m_t % 4) == 0) && (m_pend || hm);
    m_pend = m_hmq ? 1'b0 : (m_pend || hm);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Pops the oldest expected record and compares it with the DUT outputs.
  task automatic checkOutput();
    outs_t act, exp;
    string nm;
    checks++;
    act = sample();
    if (exp_q.size() == 0) begin
      $display("[TB] FAIL scoreboard_empty: got %h, expected a queued record", act);
      return;
    end
    exp = exp_q.pop_front();
    nm  = name_q.pop_front();
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Drives one clk of stimulus, queues its expected result and checks it
  // 1 time unit after the rising edge that consumes it.
  task automatic applyStimulus(input logic rs, input logic hm, input outs_t exp,
                               input string nm);
    rsync = rs;
    hmove = hm;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    checkOutput();
    rsync = 1'b0;
    hmove = 1'b0;
  endtask

  task automatic runModel(input logic rs, input logic hm, input string nm);
    modelStep(rs, hm);
    applyStimulus(rs, hm, model_outs(), nm);
  endtask

  task automatic runTrack(input logic rs, input logic hm, input string nm);
    runModel(rs, hm, nm);
    trk_step++;
    if (hmove_q) begin
      trk_n++;
      if (trk_first < 0) trk_first = trk_step;
      else if (trk_second < 0) trk_second = trk_step;
      if (!hphi1) trk_bad++;
    end
  endtask

  // Asserts reset between clock edges and checks it acts without a clock.
  task automatic doReset(input string nm);
    #2;
    reset_bar = 1'b0;
    #1;
    exp_q.push_back(mk(6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    name_q.push_back({nm, "_async"});
    checkOutput();
    @(posedge clk);
    #1;
    exp_q.push_back(mk(6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    name_q.push_back({nm, "_held"});
    checkOutput();
    @(negedge clk);
    reset_bar = 1'b1;
    modelReset();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rise [6];
    int width [6];
    int exp_rise [6];
    logic [5:0] dec, prev_dec;
    logic prev_shb;
    int shb_rise0, shb_rise1, n1, n2, overlap, viol, last1, bound;
    int shs_rise, rs_cnt, hq_cnt;

    // rsync, hmove, then expected {hcount, hphi1, hphi2, shb, rsynd, hmove_q}
    vecs[0]  = '{1'b0, 1'b0, mk(6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[1]  = '{1'b0, 1'b1, mk(6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
    vecs[2]  = '{1'b0, 1'b0, mk(6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
    vecs[3]  = '{1'b0, 1'b0, mk(6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)};
    vecs[4]  = '{1'b0, 1'b1, mk(6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[5]  = '{1'b0, 1'b0, mk(6'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)};
    vecs[6]  = '{1'b0, 1'b0, mk(6'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[7]  = '{1'b0, 1'b0, mk(6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1)};
    vecs[8]  = '{1'b1, 1'b0, mk(6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0)};
    vecs[9]  = '{1'b1, 1'b0, mk(6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0)};
    vecs[10] = '{1'b0, 1'b0, mk(6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
    vecs[11] = '{1'b0, 1'b0, mk(6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0)};
    vecs[12] = '{1'b0, 1'b0, mk(6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};
    vecs[13] = '{1'b0, 1'b0, mk(6'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)};
    vecs[14] = '{1'b1, 1'b1, mk(6'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1)};
    vecs[15] = '{1'b0, 1'b0, mk(6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)};

    exp_rise = '{16, 32, 48, 64, 72, 144};
    reset_bar = 1'b0;
    rsync     = 1'b0;
    hmove     = 1'b0;
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(6'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    name_q.push_back("reset_initial");
    checkOutput();
    @(negedge clk);
    reset_bar = 1'b1;

    $display("[TB] directed table");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rsync, vecs[i].hmove, vecs[i].exp, $sformatf("vec%0d", i));
    end

    $display("[TB] free-run three lines");
    doReset("reset_mid_slot");
    for (int k = 0; k < 6; k++) begin
      rise[k]  = -1;
      width[k] = 0;
    end
    prev_dec = '0;
    prev_shb = 1'b1;
    shb_rise0 = -1; shb_rise1 = -1;
    n1 = 0; n2 = 0; overlap = 0; viol = 0; last1 = 0;
    for (int cyc = 1; cyc <= 684; cyc++) begin
      runModel(1'b0, 1'b0, "freerun");
      dec = {shs, rhs, rcb, rhb, lrhb, cnt};
      for (int k = 0; k < 6; k++) begin
        if (dec[5-k] && !prev_dec[5-k] && rise[k] < 0) rise[k] = cyc;
        if (cyc <= 228 && dec[5-k]) width[k]++;
      end
      prev_dec = dec;
      if (shb && !prev_shb) begin
        if (shb_rise0 < 0) shb_rise0 = cyc;
        else if (shb_rise1 < 0) shb_rise1 = cyc;
      end
      prev_shb = shb;
      if (cyc <= 228) begin
        if (hphi1 && hphi2) overlap++;
        if (hphi1) begin
          n1++;
          last1 = cyc;
        end
        if (hphi2) begin
          n2++;
          if (cyc - last1 != 2) viol++;
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      check($sformatf("decode%0d_rise", k), rise[k], exp_rise[k]);
      check($sformatf("decode%0d_width", k), width[k], 4);
    end
    check("line_first_wrap", shb_rise0, 228);
    check("line_period", shb_rise1 - shb_rise0, 228);
    check("hphi1_pulses", n1, 57);
    check("hphi2_pulses", n2, 57);
    check("hphi_overlap", overlap, 0);
    check("hphi_spacing", viol, 0);

    $display("[TB] rsync mid-slot");
    bound = 0;
    while (m_t != 122 && bound < 400) begin
      runModel(1'b0, 1'b0, "seek_hc30");
      bound++;
    end
    check("seek_hc30_hcount", hcount, 30);
    runModel(1'b1, 1'b0, "rsync_mid");
    shs_rise = -1;
    rs_cnt = rsynd ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      runModel(1'b0, 1'b0, "after_rsync");
      if (shs && shs_rise < 0) shs_rise = i;
      if (rsynd) rs_cnt++;
    end
    check("rsync_shs_delay", shs_rise, 16);
    check("rsynd_width", rs_cnt, 4);

    $display("[TB] hmove re-arm");
    bound = 0;
    while ((m_t % 4) != 1 && bound < 8) begin
      runModel(1'b0, 1'b0, "seek_phase1");
      bound++;
    end
    trk_step = 0; trk_n = 0; trk_first = -1; trk_second = -1; trk_bad = 0;
    runTrack(1'b0, 1'b1, "hmove_ph1");
    runTrack(1'b0, 1'b0, "hmove_wait");
    runTrack(1'b0, 1'b0, "hmove_fire1");
    runTrack(1'b0, 1'b1, "hmove_rearm");
    for (int i = 0; i < 8; i++) runTrack(1'b0, 1'b0, "hmove_after");
    check("hmove_q_count", trk_n, 2);
    check("hmove_q_spacing", trk_second - trk_first, 4);
    check("hmove_q_on_hphi1", trk_bad, 0);

    $display("[TB] rsync with hmove");
    runModel(1'b0, 1'b0, "pre_rsync_hmove");
    runModel(1'b0, 1'b0, "pre_rsync_hmove");
    runModel(1'b1, 1'b1, "rsync_hmove");
    check("rsync_hmove_align", {hmove_q, hphi1, hcount}, {1'b1, 1'b1, 6'd0});

    $display("[TB] reset during pending hmove");
    bound = 0;
    while (m_t != 80 && bound < 400) begin
      runModel(1'b0, 1'b0, "seek_hc20");
      bound++;
    end
    check("seek_hc20_hcount", hcount, 20);
    runModel(1'b0, 1'b1, "hmove_pending");
    doReset("reset_hmove");
    hq_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      runModel(1'b0, 1'b0, "post_reset");
      if (hmove_q) hq_cnt++;
    end
    check("post_reset_hmove_q", hq_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
